// File: rtl/lib_voq_output_arbiter_pkg.sv
// rtl/lib_voq_output_arbiter_pkg.sv - shared network config: VOQ sizing and packet type
package lib_voq_output_arbiter_pkg;

    localparam int VOQ_NUM_INPUTS = 4;

    typedef struct packed {
        logic [3:0]  src;
        logic [27:0] payload;
    } packet_t;

endpackage

// File: rtl/lib_rr_arbiter.sv
// rtl/lib_rr_arbiter.sv - N-way round-robin arbiter; pointer moves past the winner on advance
module lib_rr_arbiter
    import lib_voq_output_arbiter_pkg::*;
#(
    parameter int N = VOQ_NUM_INPUTS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:N-1]           req,
    input  logic                   advance,
    output logic [0:N-1]           grant,
    output logic [$clog2(N)-1:0]   ptr
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Search starts at the pointer and wraps, so the last winner is checked last.
    always_comb begin
        grant = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                win        = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (win == PTR_W'(N - 1)) ? '0 : win + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/lib_voq_output_arbiter.sv
// rtl/lib_voq_output_arbiter.sv - per-output VOQ read arbiter with output register; LIB_VOQ_ARB_STATS_EN adds grant counters
module lib_voq_output_arbiter
    import lib_voq_output_arbiter_pkg::*;
#(
    parameter int N = VOQ_NUM_INPUTS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  packet_t [0:N-1]      i_data,
    input  logic    [0:N-1]      i_data_val,
    output logic    [0:N-1]      o_en,
    output packet_t              o_data,
    output logic                 o_data_val,
    input  logic                 i_en
`ifdef LIB_VOQ_ARB_STATS_EN
    ,
    output logic [0:N-1][15:0]   o_grant_count
`endif
);

    localparam int PTR_W = $clog2(N);

    packet_t          data_q;
    packet_t          data_d;
    logic             val_q;
    logic             val_d;
    packet_t          sel_pkt;
    logic [0:N-1]     grant;
    logic [PTR_W-1:0] unused_ptr;
    logic             space;
    logic             any_req;
    logic             do_grant;

    // The register can take a new packet when empty or when it drains this same cycle.
    assign space    = !val_q || i_en;
    assign any_req  = |i_data_val;
    assign do_grant = ce && space && any_req;

    lib_rr_arbiter #(.N(N)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (i_data_val),
        .advance (do_grant),
        .grant   (grant),
        .ptr     (unused_ptr)
    );

    assign o_en = (do_grant && !reset) ? grant : '0;

    always_comb begin
        sel_pkt = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                sel_pkt = i_data[k];
            end
        end
    end

    always_comb begin
        data_d = data_q;
        val_d  = val_q;
        if (ce && space) begin
            val_d = any_req;
            if (any_req) begin
                data_d = sel_pkt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            val_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            val_q  <= val_d;
        end
    end

    assign o_data     = data_q;
    assign o_data_val = val_q;

`ifdef LIB_VOQ_ARB_STATS_EN
    logic [0:N-1][15:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (o_en[k] && cnt_q[k] != 16'hFFFF) begin
                    cnt_q[k] <= cnt_q[k] + 16'd1;
                end
            end
        end
    end

    assign o_grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_lib_voq_output_arbiter.sv
// tb/tb_lib_voq_output_arbiter.sv - directed and random checks of lib_voq_output_arbiter against a scoreboard
module tb_lib_voq_output_arbiter;
    import lib_voq_output_arbiter_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            ce;
    logic            i_en;
    packet_t [0:N-1] i_data;
    logic [0:N-1]    i_data_val;
    logic [0:N-1]    o_en;
    packet_t         o_data;
    logic            o_data_val;
`ifdef LIB_VOQ_ARB_STATS_EN
    logic [0:N-1][15:0] o_grant_count;
`endif

    int      n_assert = 0;
    int      n_fail   = 0;
    int      mptr     = 0;
    int      mcnt [N];
    packet_t sb [$];

    always #5 clk = ~clk;

    lib_voq_output_arbiter #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .i_data     (i_data),
        .i_data_val (i_data_val),
        .o_en       (o_en),
        .o_data     (o_data),
        .o_data_val (o_data_val),
        .i_en       (i_en)
`ifdef LIB_VOQ_ARB_STATS_EN
        ,
        .o_grant_count (o_grant_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mptr = 0;
        for (int k = 0; k < N; k++) mcnt[k] = 0;
    endtask

    // One cycle: drive after the falling edge, check before the rising edge, update the model at it.
    task automatic step(input logic [0:N-1] v, input logic en, input logic c,
                        input logic use_exp, input logic [0:N-1] exp_en);
        logic [0:N-1] g;
        logic         sp;
        int           w;
        packet_t      pkt;
        i_data_val = v;
        i_en       = en;
        ce         = c;
        for (int k = 0; k < N; k++) i_data[k] = {4'(k), 28'($urandom)};
        #1;
        g   = '0;
        w   = -1;
        pkt = '0;
        sp  = (sb.size() == 0) || en;
        if (c && sp) begin
            for (int i = 0; i < N; i++) begin
                if (w < 0 && v[(mptr + i) % N]) w = (mptr + i) % N;
            end
        end
        if (w >= 0) begin
            g[w] = 1'b1;
            pkt  = i_data[w];
        end
        check("o_en", 64'(o_en), 64'(g));
        if (use_exp) check("o_en_directed", 64'(o_en), 64'(exp_en));
        check("o_data_val", 64'(o_data_val), 64'(sb.size() != 0));
        if (sb.size() != 0) check("o_data", 64'(o_data), 64'(sb[0]));
        @(posedge clk);
        if (c && sp) begin
            if (sb.size() != 0) void'(sb.pop_front());
            if (w >= 0) begin
                sb.push_back(pkt);
                mptr = (w == N - 1) ? 0 : w + 1;
                if (mcnt[w] != 65535) mcnt[w]++;
            end
        end
        @(negedge clk);
    endtask

    logic [0:N-1] rr_seq [5];

    initial begin
        rr_seq[0] = 4'b1000; rr_seq[1] = 4'b0100; rr_seq[2] = 4'b0010;
        rr_seq[3] = 4'b0001; rr_seq[4] = 4'b1000;
        reset      = 1'b1;
        ce         = 1'b1;
        i_en       = 1'b1;
        i_data_val = 4'b1111;
        for (int k = 0; k < N; k++) i_data[k] = {4'(k), 28'h5A5A5A5};
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_o_data_val", 64'(o_data_val), 64'(0));
        check("reset_o_data", 64'(o_data), 64'(0));
        check("reset_o_en", 64'(o_en), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 1'b1, 1'b1, rr_seq[i]);

        step(4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010);
        step(4'b0110, 1'b1, 1'b1, 1'b1, 4'b0100);
        step(4'b0110, 1'b1, 1'b1, 1'b1, 4'b0010);

        for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 1'b1, 1'b1, 4'b0000);
        step(4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000);

        step(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0100);
        step(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0010);
        step(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001);

        #2;
        reset = 1'b1;
        #1;
        check("async_reset_o_data_val", 64'(o_data_val), 64'(0));
        check("async_reset_o_data", 64'(o_data), 64'(0));
        check("async_reset_o_en", 64'(o_en), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(4'b0101, 1'b1, 1'b1, 1'b1, 4'b0100);

        for (int i = 0; i < 300; i++) begin
            step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0), 1'b0, 4'b0000);
        end

`ifdef LIB_VOQ_ARB_STATS_EN
        for (int k = 0; k < N; k++) check("grant_count", 64'(o_grant_count[k]), 64'(mcnt[k]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
